// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM states,
// processor default geometry and the address range helper.
package reg_file_mp_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   localparam int RF_DATA_W = 8;
   localparam int RF_DEPTH  = 8;

   // Non-power-of-two depths leave a hole at the top of the address space.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bundle of the register file: read ports, write
// port with back-pressure, and the clear request/status pair.
interface reg_file_mp_if
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = $clog2(RF_DEPTH),
   parameter int N_RD   = 2
);
   logic [N_RD-1:0]        rd_en;
   logic [N_RD*ADDR_W-1:0] rd_addr;
   logic [N_RD*DATA_W-1:0] rd_data;
   logic [N_RD-1:0]        rd_valid;
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [DATA_W-1:0]      wr_data;
   logic                   wr_ready;
   logic                   wr_ack;
   logic                   clr_req;
   logic                   clr_busy;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
      input  rd_data, rd_valid, wr_ready, wr_ack, clr_busy
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
      output rd_data, rd_valid, wr_ready, wr_ack, clr_busy
   );
endinterface

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: sweeps every entry to zero, one per cycle, while holding
// off writers through wr_ready.
module reg_file_clr_seq
   import reg_file_mp_pkg::*;
#(
   parameter int DEPTH  = RF_DEPTH,
   parameter int ADDR_W = $clog2(RF_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req_i,
   output logic              clr_busy_o,
   output logic              wr_ready_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   clr_state_e        state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              busy_q;
   logic              ready_q;

   // Requests arriving while a sweep runs are dropped, not queued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr_req_i) begin
                  state_q <= CLEAR;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end
            end
            CLEAR: begin
               if (ptr_q == LAST_ADDR) begin
                  state_q <= IDLE;
                  ptr_q   <= '0;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign clr_we_o   = (state_q == CLEAR);
   assign clr_addr_o = ptr_q;
   assign clr_busy_o = busy_q;
   assign wr_ready_o = ready_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file with N_RD registered read ports, one write port,
// write-first bypass, optional hard-wired zero entry and a hardware clear.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int DEPTH    = RF_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int N_RD     = 2,
   parameter int ZERO_REG = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   reg_file_mp_if.slave  rf_if
);

   function automatic logic hardwired_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              clr_busy;
   logic              wr_ready;

   reg_file_clr_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_req_i  (rf_if.clr_req),
      .clr_busy_o (clr_busy),
      .wr_ready_o (wr_ready),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   logic wr_acc;
   logic wr_inr;
   logic wr_commit;

   // Writes to the zero entry are accepted and acknowledged but not stored.
   assign wr_acc    = rf_if.wr_en && wr_ready;
   assign wr_inr    = addr_in_range(32'(rf_if.wr_addr), DEPTH);
   assign wr_commit = wr_acc && wr_inr && !hardwired_zero(rf_if.wr_addr);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (clr_we && (clr_addr == ADDR_W'(i)))
               mem_q[i] <= '0;
            else if (wr_commit && (rf_if.wr_addr == ADDR_W'(i)))
               mem_q[i] <= rf_if.wr_data;
         end
      end
   end

   logic [N_RD-1:0][DATA_W-1:0] rd_data_d;
   logic [N_RD-1:0][DATA_W-1:0] rd_data_q;
   logic [N_RD-1:0]             rd_valid_q;
   logic                        wr_ack_q;

   // Each port sees the array as it will be after this edge's clear/write.
   for (genvar k = 0; k < N_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              force_zero;
      logic              hit_wr;

      assign addr       = rf_if.rd_addr[k*ADDR_W +: ADDR_W];
      assign force_zero = !addr_in_range(32'(addr), DEPTH) || hardwired_zero(addr) ||
                          (clr_we && (clr_addr == addr));
      assign hit_wr     = wr_commit && (rf_if.wr_addr == addr);
      assign rd_data_d[k] = force_zero ? '0 :
                            hit_wr     ? rf_if.wr_data : mem_q[addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= '0;
         wr_ack_q   <= 1'b0;
      end else begin
         for (int k = 0; k < N_RD; k++) begin
            if (rf_if.rd_en[k]) rd_data_q[k] <= rd_data_d[k];
         end
         rd_valid_q <= rf_if.rd_en;
         wr_ack_q   <= wr_acc && wr_inr;
      end
   end

   assign rf_if.rd_data  = rd_data_q;
   assign rf_if.rd_valid = rd_valid_q;
   assign rf_if.wr_ack   = wr_ack_q;
   assign rf_if.wr_ready = wr_ready;
   assign rf_if.clr_busy = clr_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations (8 deep, 8 deep with zero
// register, 6 deep) checked against an array-level model every cycle.
module tb_reg_file_mp;

   logic clk;
   logic rst_n;
   bit   chk_en;
   int   checks;
   int   failures;

   reg_file_mp_if #(.DATA_W(8), .ADDR_W(3), .N_RD(2)) bus0 ();
   reg_file_mp_if #(.DATA_W(8), .ADDR_W(3), .N_RD(2)) bus1 ();
   reg_file_mp_if #(.DATA_W(8), .ADDR_W(3), .N_RD(2)) bus2 ();

   reg_file_mp #(.DATA_W(8), .DEPTH(8), .N_RD(2), .ZERO_REG(0)) dut0 (.clk(clk), .rst_n(rst_n), .rf_if(bus0));
   reg_file_mp #(.DATA_W(8), .DEPTH(8), .N_RD(2), .ZERO_REG(1)) dut1 (.clk(clk), .rst_n(rst_n), .rf_if(bus1));
   reg_file_mp #(.DATA_W(8), .DEPTH(6), .N_RD(2), .ZERO_REG(0)) dut2 (.clk(clk), .rst_n(rst_n), .rf_if(bus2));

   logic [1:0] rd_en_v   [3];
   logic [5:0] rd_addr_v [3];
   logic       wr_en_v   [3];
   logic [2:0] wr_addr_v [3];
   logic [7:0] wr_data_v [3];
   logic       clr_req_v [3];

   logic [15:0] rdd_w  [3];
   logic [1:0]  rdv_w  [3];
   logic        ack_w  [3];
   logic        busy_w [3];
   logic        rdy_w  [3];

   assign bus0.rd_en = rd_en_v[0];  assign bus0.rd_addr = rd_addr_v[0];
   assign bus0.wr_en = wr_en_v[0];  assign bus0.wr_addr = wr_addr_v[0];
   assign bus0.wr_data = wr_data_v[0]; assign bus0.clr_req = clr_req_v[0];
   assign bus1.rd_en = rd_en_v[1];  assign bus1.rd_addr = rd_addr_v[1];
   assign bus1.wr_en = wr_en_v[1];  assign bus1.wr_addr = wr_addr_v[1];
   assign bus1.wr_data = wr_data_v[1]; assign bus1.clr_req = clr_req_v[1];
   assign bus2.rd_en = rd_en_v[2];  assign bus2.rd_addr = rd_addr_v[2];
   assign bus2.wr_en = wr_en_v[2];  assign bus2.wr_addr = wr_addr_v[2];
   assign bus2.wr_data = wr_data_v[2]; assign bus2.clr_req = clr_req_v[2];

   assign rdd_w[0] = bus0.rd_data;  assign rdv_w[0] = bus0.rd_valid;  assign ack_w[0] = bus0.wr_ack;
   assign busy_w[0] = bus0.clr_busy; assign rdy_w[0] = bus0.wr_ready;
   assign rdd_w[1] = bus1.rd_data;  assign rdv_w[1] = bus1.rd_valid;  assign ack_w[1] = bus1.wr_ack;
   assign busy_w[1] = bus1.clr_busy; assign rdy_w[1] = bus1.wr_ready;
   assign rdd_w[2] = bus2.rd_data;  assign rdv_w[2] = bus2.rd_valid;  assign ack_w[2] = bus2.wr_ack;
   assign busy_w[2] = bus2.clr_busy; assign rdy_w[2] = bus2.wr_ready;

   // Reference model: array contents plus what each output must show.
   logic [7:0]  m_mem [3][8];
   logic [15:0] m_rdd [3];
   logic [1:0]  m_rdv [3];
   logic        m_ack [3];
   int          m_left [3];
   int          m_ptr [3];
   logic        m_acc [3];

   function automatic int dep_of(input int d);
      return (d == 2) ? 6 : 8;
   endfunction

   function automatic bit zr_of(input int d);
      return (d == 1);
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, d, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 8; i++) m_mem[d][i] = 8'h00;
         m_rdd[d] = 16'h0; m_rdv[d] = 2'b00; m_ack[d] = 1'b0;
         m_left[d] = 0; m_ptr[d] = 0; m_acc[d] = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 3; d++) begin
         logic [7:0] nm [8];
         bit busy, acc, inr;
         int wa;
         for (int i = 0; i < 8; i++) nm[i] = m_mem[d][i];
         busy = (m_left[d] != 0);
         acc  = wr_en_v[d] && !busy;
         wa   = int'(wr_addr_v[d]);
         inr  = wa < dep_of(d);
         if (busy) nm[m_ptr[d]] = 8'h00;
         if (acc && inr && !(zr_of(d) && wa == 0)) nm[wa] = wr_data_v[d];
         m_ack[d] = acc && inr;
         for (int k = 0; k < 2; k++) begin
            if (rd_en_v[d][k]) begin
               int ra;
               ra = int'(rd_addr_v[d][k*3 +: 3]);
               m_rdd[d][k*8 +: 8] = (ra < dep_of(d)) ? nm[ra] : 8'h00;
            end
         end
         m_rdv[d] = rd_en_v[d];
         for (int i = 0; i < 8; i++) m_mem[d][i] = nm[i];
         if (busy) begin
            m_ptr[d]++;
            m_left[d]--;
         end else if (clr_req_v[d]) begin
            m_left[d] = dep_of(d);
            m_ptr[d]  = 0;
         end
         m_acc[d] = acc;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic idle_all();
      for (int d = 0; d < 3; d++) begin
         rd_en_v[d] = 2'b00; rd_addr_v[d] = 6'd0;
         wr_en_v[d] = 1'b0;  wr_addr_v[d] = 3'd0; wr_data_v[d] = 8'h00;
         clr_req_v[d] = 1'b0;
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every-cycle comparison of all three DUTs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
               chk("rd_valid", d, 32'(rdv_w[d]), 32'(m_rdv[d]));
               chk("rd_data",  d, 32'(rdd_w[d]), 32'(m_rdd[d]));
               chk("wr_ack",   d, 32'(ack_w[d]), 32'(m_ack[d]));
               chk("clr_busy", d, 32'(busy_w[d]), 32'(m_left[d] != 0));
               chk("wr_ready", d, 32'(rdy_w[d]), 32'(m_left[d] == 0));
            end
         end
      end
   end

   initial begin
      int busy_cnt, rlow_cnt, guard;
      int cnt [3];
      checks = 0; failures = 0; chk_en = 1'b0;
      idle_all();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      model_reset();
      chk_en = 1'b1;
      repeat (3) cyc();
      for (int d = 0; d < 3; d++) begin
         chk("reset_rd_data", d, 32'(rdd_w[d]), 32'h0);
         chk("reset_wr_ready", d, 32'(rdy_w[d]), 32'h1);
      end
      rst_n = 1'b1;

      // Read every address on both ports after reset.
      for (int a = 0; a < 8; a++) begin
         for (int d = 0; d < 3; d++) begin
            rd_en_v[d] = 2'b11;
            rd_addr_v[d] = {3'(a), 3'(a)};
         end
         cyc();
         for (int d = 0; d < 3; d++) begin
            chk("post_reset_rdv", d, 32'(rdv_w[d]), 32'h3);
            chk("post_reset_rdd", d, 32'(rdd_w[d]), 32'h0);
         end
      end
      idle_all();
      cyc();
      for (int d = 0; d < 3; d++) chk("no_rd_en_rdv", d, 32'(rdv_w[d]), 32'h0);

      // Same-edge write/read bypass, then a second port reads it back.
      wr_en_v[0] = 1'b1; wr_addr_v[0] = 3'd3; wr_data_v[0] = 8'hA5;
      rd_en_v[0] = 2'b01; rd_addr_v[0] = 6'd3;
      cyc();
      chk("bypass_rdd0", 0, 32'(rdd_w[0][7:0]), 32'hA5);
      chk("bypass_ack", 0, 32'(ack_w[0]), 32'h1);
      idle_all();
      rd_en_v[0] = 2'b10; rd_addr_v[0] = {3'd3, 3'd0};
      cyc();
      chk("ack_one_cycle", 0, 32'(ack_w[0]), 32'h0);
      chk("port1_rdd", 0, 32'(rdd_w[0][15:8]), 32'hA5);
      chk("port1_rdv", 0, 32'(rdv_w[0]), 32'h2);

      // Hard-wired zero register.
      idle_all();
      wr_en_v[1] = 1'b1; wr_addr_v[1] = 3'd0; wr_data_v[1] = 8'hFF;
      cyc();
      chk("zr_write_ack", 1, 32'(ack_w[1]), 32'h1);
      idle_all();
      rd_en_v[1] = 2'b01; rd_addr_v[1] = 6'd0;
      cyc();
      chk("zr_read0", 1, 32'(rdd_w[1][7:0]), 32'h00);
      chk("zr_ack_once", 1, 32'(ack_w[1]), 32'h0);
      idle_all();
      wr_en_v[1] = 1'b1; wr_addr_v[1] = 3'd1; wr_data_v[1] = 8'h11;
      cyc();
      idle_all();
      rd_en_v[1] = 2'b01; rd_addr_v[1] = 6'd1;
      cyc();
      chk("zr_read1", 1, 32'(rdd_w[1][7:0]), 32'h11);

      // Depth 6: out-of-range write and read.
      idle_all();
      wr_en_v[2] = 1'b1; wr_addr_v[2] = 3'd7; wr_data_v[2] = 8'h3C;
      cyc();
      chk("oor_no_ack", 2, 32'(ack_w[2]), 32'h0);
      wr_addr_v[2] = 3'd5; wr_data_v[2] = 8'h55;
      cyc();
      chk("d6_ack", 2, 32'(ack_w[2]), 32'h1);
      idle_all();
      rd_en_v[2] = 2'b01; rd_addr_v[2] = 6'd5;
      cyc();
      chk("d6_read5", 2, 32'(rdd_w[2][7:0]), 32'h55);
      rd_addr_v[2] = 6'd7;
      cyc();
      chk("oor_read7", 2, 32'(rdd_w[2][7:0]), 32'h00);
      chk("oor_read7_vld", 2, 32'(rdv_w[2]), 32'h1);

      // Fill, then clear with a coincident write and a write held across it.
      idle_all();
      for (int a = 0; a < 8; a++) begin
         wr_en_v[0] = 1'b1; wr_addr_v[0] = 3'(a); wr_data_v[0] = 8'(8'h10 + a);
         cyc();
         chk("fill_ack", 0, 32'(ack_w[0]), 32'h1);
      end
      wr_addr_v[0] = 3'd5; wr_data_v[0] = 8'h77; clr_req_v[0] = 1'b1;
      cyc();
      chk("clr_wr_ack", 0, 32'(ack_w[0]), 32'h1);
      busy_cnt = busy_w[0] ? 1 : 0;
      rlow_cnt = rdy_w[0] ? 0 : 1;
      wr_addr_v[0] = 3'd2; wr_data_v[0] = 8'h99;
      guard = 0;
      while (busy_w[0] && guard < 20) begin
         clr_req_v[0] = (guard < 3);
         cyc();
         guard++;
         if (busy_w[0]) busy_cnt++;
         if (!rdy_w[0]) rlow_cnt++;
      end
      clr_req_v[0] = 1'b0;
      chk("clr_busy_cycles", 0, 32'(busy_cnt), 32'd8);
      chk("wr_ready_low_cycles", 0, 32'(rlow_cnt), 32'd8);
      cyc();
      chk("held_write_ack", 0, 32'(ack_w[0]), 32'h1);
      idle_all();
      for (int a = 0; a < 8; a++) begin
         rd_en_v[0] = 2'b11; rd_addr_v[0] = {3'(a), 3'(a)};
         cyc();
         chk("after_clr_read", 0, 32'(rdd_w[0]), (a == 2) ? 32'h9999 : 32'h0);
      end

      // Reset in the middle of a clear, then a full sweep afterwards.
      idle_all();
      for (int d = 0; d < 3; d++) clr_req_v[d] = 1'b1;
      cyc();
      idle_all();
      cyc();
      cyc();
      chk("mid_clr_busy", 0, 32'(busy_w[0]), 32'h1);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < 3; d++) chk("async_rst_busy", d, 32'(busy_w[d]), 32'h0);
      cyc();
      rst_n = 1'b1;
      rd_en_v[0] = 2'b11; rd_addr_v[0] = {3'd3, 3'd2};
      rd_en_v[1] = 2'b01; rd_addr_v[1] = 6'd1;
      cyc();
      chk("rst_read_d0", 0, 32'(rdd_w[0]), 32'h0);
      chk("rst_read_d1", 1, 32'(rdd_w[1]), 32'h0);
      idle_all();
      for (int d = 0; d < 3; d++) clr_req_v[d] = 1'b1;
      cyc();
      idle_all();
      for (int d = 0; d < 3; d++) cnt[d] = busy_w[d] ? 1 : 0;
      repeat (12) begin
         cyc();
         for (int d = 0; d < 3; d++) if (busy_w[d]) cnt[d]++;
      end
      for (int d = 0; d < 3; d++) chk("sweep_len", d, 32'(cnt[d]), 32'(dep_of(d)));

      // Randomised traffic obeying the hold-until-accepted write protocol.
      for (int n = 0; n < 3000; n++) begin
         for (int d = 0; d < 3; d++) begin
            if (!(wr_en_v[d] && !m_acc[d])) begin
               wr_en_v[d]   = 1'($urandom_range(0, 1));
               wr_addr_v[d] = 3'($urandom_range(0, 7));
               wr_data_v[d] = 8'($urandom);
            end
            rd_en_v[d]   = 2'($urandom_range(0, 3));
            rd_addr_v[d] = 6'($urandom_range(0, 63));
            clr_req_v[d] = ($urandom_range(0, 40) == 0);
         end
         cyc();
      end

      idle_all();
      cyc();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
